// File: rtl/rf_wport_arbiter.sv
// Two-producer arbiter for the register file write port: fixed priority to A, with a forced B grant after STARVE_LIMIT blocked cycles.
// Ready signals are combinational. The write is registered, so a transfer at edge N drives the regfile in cycle N+1.
module rf_wport_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [4:0]       a_addr,
   input  logic [31:0]      a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [4:0]       b_addr,
   input  logic [31:0]      b_data,
   output logic             b_ready,
   output logic             write_enable,
   output logic [4:0]       w_addr,
   output logic [31:0]      w_data,
   output logic             grant_src,
   output logic [CNT_W-1:0] starve_events
);

   localparam int SC_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
   localparam logic [SC_W-1:0]  STARVE_LAST = SC_W'(STARVE_LIMIT - 1);
   localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
   localparam logic [CNT_W-1:0] EVT_MAX     = '1;
   localparam logic [CNT_W-1:0] EVT_ONE     = CNT_W'(1);

   typedef enum logic {
      PRIO_A  = 1'b0,
      FORCE_B = 1'b1
   } state_t;

   state_t          state;
   logic [SC_W-1:0] starve_cnt;
   logic            a_xfer;
   logic            b_xfer;
   logic            b_blocked;

   // Readiness is held low during reset so no producer sees a phantom accept.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (!reset) begin
         if (state == PRIO_A) begin
            a_ready = 1'b1;
            b_ready = !a_valid;
         end else begin
            a_ready = !b_valid;
            b_ready = 1'b1;
         end
      end
   end

   assign a_xfer    = a_valid && a_ready;
   assign b_xfer    = b_valid && b_ready;
   assign b_blocked = b_valid && !b_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= PRIO_A;
         starve_cnt    <= '0;
         write_enable  <= 1'b0;
         w_addr        <= '0;
         w_data        <= '0;
         grant_src     <= 1'b0;
         starve_events <= '0;
      end else begin
         // x0 is hardwired zero: the transfer is accepted but never reaches the regfile.
         write_enable <= (a_xfer && (a_addr != 5'd0)) || (b_xfer && (b_addr != 5'd0));
         if (a_xfer) begin
            w_addr    <= a_addr;
            w_data    <= a_data;
            grant_src <= 1'b0;
         end else if (b_xfer) begin
            w_addr    <= b_addr;
            w_data    <= b_data;
            grant_src <= 1'b1;
         end

         case (state)
            PRIO_A: begin
               if (b_blocked) begin
                  if (starve_cnt == STARVE_LAST) begin
                     state      <= FORCE_B;
                     starve_cnt <= '0;
                     if (starve_events != EVT_MAX)
                        starve_events <= starve_events + EVT_ONE;
                  end else begin
                     starve_cnt <= starve_cnt + SC_ONE;
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            default: begin
               // The forced window lasts one cycle whether or not B used it.
               state      <= PRIO_A;
               starve_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed scenarios plus a randomized run against a grant/starvation model.
module tb_rf_wport_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        reset;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [4:0]  a_addr, b_addr, w_addr;
   logic [31:0] a_data, b_data, w_data;
   logic        write_enable, grant_src;
   logic [15:0] starve_events;

   logic        p_a_valid, p_b_valid, p_a_ready, p_b_ready;
   logic [4:0]  p_a_addr, p_b_addr, p_w_addr;
   logic [31:0] p_a_data, p_b_data, p_w_data;
   logic        p_we, p_src;
   logic [1:0]  p_events;

   int checks = 0;
   int passed = 0;

   rf_wport_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .write_enable(write_enable), .w_addr(w_addr), .w_data(w_data),
      .grant_src(grant_src), .starve_events(starve_events)
   );

   rf_wport_arbiter #(.STARVE_LIMIT(1), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset),
      .a_valid(p_a_valid), .a_addr(p_a_addr), .a_data(p_a_data), .a_ready(p_a_ready),
      .b_valid(p_b_valid), .b_addr(p_b_addr), .b_data(p_b_data), .b_ready(p_b_ready),
      .write_enable(p_we), .w_addr(p_w_addr), .w_data(p_w_data),
      .grant_src(p_src), .starve_events(p_events)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Regfiles as seen from each DUT's write port.
   logic [31:0] rf_dut [32] = '{default: 32'd0};
   logic [31:0] rf1    [32] = '{default: 32'd0};
   always @(posedge clk) begin
      if (write_enable) rf_dut[w_addr] <= w_data;
      if (p_we)         rf1[p_w_addr]  <= p_w_data;
   end

   // Reference model: A wins unless B has been refused LIMIT cycles in a row,
   // in which case the following cycle belongs to B.
   logic        m_force, m_ar, m_br, m_ga_n, m_gb_n, m_ga, m_gb, m_we, m_src;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_run, m_events;
   logic [31:0] m_rf [32] = '{default: 32'd0};

   always_comb begin
      m_ar   = m_force ? !b_valid : 1'b1;
      m_br   = m_force ? 1'b1 : !a_valid;
      m_ga_n = a_valid && m_ar;
      m_gb_n = b_valid && m_br;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_force  <= 1'b0;
         m_run    <= 0;
         m_events <= 0;
         m_we     <= 1'b0;
         m_src    <= 1'b0;
         m_addr   <= 5'd0;
         m_data   <= 32'd0;
         m_ga     <= 1'b0;
         m_gb     <= 1'b0;
      end else begin
         if (m_we) m_rf[m_addr] <= m_data;
         m_ga <= m_ga_n;
         m_gb <= m_gb_n;
         m_we <= (m_ga_n && a_addr != 5'd0) || (m_gb_n && b_addr != 5'd0);
         if (m_ga_n) begin
            m_src <= 1'b0; m_addr <= a_addr; m_data <= a_data;
         end else if (m_gb_n) begin
            m_src <= 1'b1; m_addr <= b_addr; m_data <= b_data;
         end
         if (m_force) begin
            m_force <= 1'b0;
            m_run   <= 0;
         end else if (b_valid && !m_gb_n) begin
            if (m_run + 1 >= LIMIT) begin
               m_force  <= 1'b1;
               m_run    <= 0;
               m_events <= (m_events == 65535) ? m_events : m_events + 1;
            end else begin
               m_run <= m_run + 1;
            end
         end else begin
            m_run <= 0;
         end
      end
   end

   task automatic idle_inputs;
      a_valid = 0; b_valid = 0; p_a_valid = 0; p_b_valid = 0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      a_valid = 1; a_addr = 5'd3; a_data = 32'h1; b_valid = 1; b_addr = 5'd4; b_data = 32'h2;
      p_a_valid = 0; p_a_addr = 0; p_a_data = 0; p_b_valid = 0; p_b_addr = 0; p_b_data = 0;
      #13;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) $display("FAIL reset_ready: a=%b b=%b want 0 0", a_ready, b_ready); else passed++;
      checks++; if (write_enable !== 1'b0) $display("FAIL reset_we: got %b want 0", write_enable); else passed++;
      checks++; if (w_addr !== 5'd0 || w_data !== 32'd0) $display("FAIL reset_wdat: addr=%0d data=%h want 0 0", w_addr, w_data); else passed++;
      checks++; if (grant_src !== 1'b0 || starve_events !== 16'd0) $display("FAIL reset_src_evt: src=%b evt=%0d want 0 0", grant_src, starve_events); else passed++;
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
   endtask

   task automatic test_a_only;
      a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF; b_valid = 0;
      #1;
      checks++; if (a_ready !== 1'b1) $display("FAIL a_only_ready: got %b want 1", a_ready); else passed++;
      @(posedge clk); @(negedge clk);
      a_valid = 0;
      checks++; if (write_enable !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEADBEEF || grant_src !== 1'b0)
         $display("FAIL a_only_write: we=%b addr=%0d data=%h src=%b want 1 5 deadbeef 0", write_enable, w_addr, w_data, grant_src); else passed++;
      @(posedge clk); @(negedge clk);
      checks++; if (write_enable !== 1'b0) $display("FAIL a_only_idle: we=%b want 0", write_enable); else passed++;
   endtask

   task automatic test_b_back_to_back;
      for (int i = 1; i <= 3; i++) begin
         b_valid = 1; b_addr = 5'(i); b_data = 32'hB000_0000 + 32'(i);
         #1;
         checks++; if (b_ready !== 1'b1) $display("FAIL b_b2b_ready%0d: got %b want 1", i, b_ready); else passed++;
         @(posedge clk); @(negedge clk);
         checks++; if (write_enable !== 1'b1 || w_addr !== 5'(i) || grant_src !== 1'b1 || w_data !== 32'hB000_0000 + 32'(i))
            $display("FAIL b_b2b_write%0d: we=%b addr=%0d src=%b data=%h", i, write_enable, w_addr, grant_src, w_data); else passed++;
      end
      b_valid = 0;
      @(posedge clk); @(negedge clk);
      checks++; if (write_enable !== 1'b0) $display("FAIL b_b2b_idle: we=%b want 0", write_enable); else passed++;
   endtask

   task automatic test_contention;
      logic is_b;
      do_reset();
      a_valid = 1; a_addr = 5'd1; a_data = $urandom;
      b_valid = 1; b_addr = 5'd20; b_data = 32'h0B0B_0000;
      for (int c = 0; c < 10; c++) begin
         is_b = (c == 4) || (c == 9);
         #1;
         checks++; if (a_ready !== !is_b || b_ready !== is_b)
            $display("FAIL contention_ready_c%0d: a=%b b=%b want %b %b", c, a_ready, b_ready, !is_b, is_b); else passed++;
         @(posedge clk); @(negedge clk);
         checks++; if (write_enable !== 1'b1 || grant_src !== is_b)
            $display("FAIL contention_grant_c%0d: we=%b src=%b want 1 %b", c, write_enable, grant_src, is_b); else passed++;
         if (is_b) begin
            b_addr = b_addr + 5'd1; b_data = b_data + 32'd1;
         end else begin
            a_addr = 5'(c + 2); a_data = $urandom;
         end
      end
      checks++; if (starve_events !== 16'd2) $display("FAIL contention_events: got %0d want 2", starve_events); else passed++;
      idle_inputs();
   endtask

   task automatic test_x0;
      do_reset();
      b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
      @(posedge clk); @(negedge clk);
      b_valid = 0;
      a_valid = 1; a_addr = 5'd0; a_data = 32'd7;
      #1;
      checks++; if (a_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", a_ready); else passed++;
      @(posedge clk); @(negedge clk);
      a_valid = 0;
      checks++; if (write_enable !== 1'b0 || grant_src !== 1'b0)
         $display("FAIL x0_write: we=%b src=%b want 0 0", write_enable, grant_src); else passed++;
   endtask

   task automatic test_same_addr;
      do_reset();
      p_a_valid = 1; p_a_addr = 5'd7; p_a_data = 32'd1;
      p_b_valid = 1; p_b_addr = 5'd7; p_b_data = 32'd2;
      #1;
      checks++; if (p_a_ready !== 1'b1 || p_b_ready !== 1'b0) $display("FAIL same_addr_c0: a=%b b=%b want 1 0", p_a_ready, p_b_ready); else passed++;
      @(posedge clk); @(negedge clk);
      p_a_valid = 0;
      checks++; if (p_we !== 1'b1 || p_src !== 1'b0 || p_w_data !== 32'd1) $display("FAIL same_addr_first: we=%b src=%b data=%0d want 1 0 1", p_we, p_src, p_w_data); else passed++;
      #1;
      checks++; if (p_b_ready !== 1'b1) $display("FAIL same_addr_c1: b=%b want 1", p_b_ready); else passed++;
      @(posedge clk); @(negedge clk);
      p_b_valid = 0;
      checks++; if (p_we !== 1'b1 || p_src !== 1'b1 || p_w_data !== 32'd2) $display("FAIL same_addr_second: we=%b src=%b data=%0d want 1 1 2", p_we, p_src, p_w_data); else passed++;
      @(posedge clk); @(negedge clk);
      checks++; if (rf1[7] !== 32'd2) $display("FAIL same_addr_final: x7=%0d want 2", rf1[7]); else passed++;
   endtask

   task automatic test_saturation;
      do_reset();
      p_a_valid = 1; p_a_addr = 5'd3; p_a_data = 32'd0;
      p_b_valid = 1; p_b_addr = 5'd4; p_b_data = 32'd0;
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (p_a_ready !== (i % 2 == 0) || p_b_ready !== (i % 2 == 1))
            $display("FAIL sat_ready_c%0d: a=%b b=%b", i, p_a_ready, p_b_ready); else passed++;
         @(posedge clk); @(negedge clk);
         if (i == 2) begin
            checks++; if (p_events !== 2'd2) $display("FAIL sat_events_mid: got %0d want 2", p_events); else passed++;
         end
         if (i % 2 == 0) p_a_data = p_a_data + 32'd1; else p_b_data = p_b_data + 32'd1;
      end
      checks++; if (p_events !== 2'd3) $display("FAIL sat_events_final: got %0d want 3", p_events); else passed++;
      idle_inputs();
   endtask

   task automatic test_reset_mid_force;
      do_reset();
      a_valid = 1; a_addr = 5'd10; a_data = 32'h100;
      b_valid = 1; b_addr = 5'd11; b_data = 32'h200;
      for (int c = 0; c < LIMIT; c++) begin
         @(posedge clk); @(negedge clk);
         a_addr = a_addr + 5'd1; a_data = $urandom;
      end
      #1;
      checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1 || starve_events !== 16'd1)
         $display("FAIL midreset_pre: a=%b b=%b evt=%0d want 0 1 1", a_ready, b_ready, starve_events); else passed++;
      #1 reset = 1'b1;
      #1;
      checks++; if (write_enable !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || starve_events !== 16'd0)
         $display("FAIL midreset_async: we=%b a=%b b=%b evt=%0d want 0 0 0 0", write_enable, a_ready, b_ready, starve_events); else passed++;
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++; if (write_enable !== 1'b0) $display("FAIL midreset_after: we=%b want 0", write_enable); else passed++;
      a_valid = 1; b_valid = 1;
      for (int c = 0; c <= LIMIT; c++) begin
         #1;
         checks++; if (a_ready !== (c < LIMIT) || b_ready !== (c == LIMIT))
            $display("FAIL midreset_recover_c%0d: a=%b b=%b", c, a_ready, b_ready); else passed++;
         @(posedge clk); @(negedge clk);
         if (c < LIMIT) begin a_addr = a_addr + 5'd1; a_data = $urandom; end
      end
      idle_inputs();
   endtask

   task automatic test_random;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         checks++; if (write_enable !== m_we || grant_src !== m_src)
            $display("FAIL rand_out_n%0d: we=%b src=%b want %b %b", n, write_enable, grant_src, m_we, m_src); else passed++;
         if (m_we) begin
            checks++; if (w_addr !== m_addr || w_data !== m_data)
               $display("FAIL rand_wdat_n%0d: addr=%0d data=%h want %0d %h", n, w_addr, w_data, m_addr, m_data); else passed++;
         end
         checks++; if (starve_events !== 16'(m_events))
            $display("FAIL rand_events_n%0d: got %0d want %0d", n, starve_events, m_events); else passed++;
         if (!a_valid || m_ga) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_addr  = 5'($urandom_range(0, 31));
            a_data  = $urandom;
         end
         if (!b_valid || m_gb) begin
            b_valid = ($urandom_range(0, 1) != 0);
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = $urandom;
         end
         #1;
         checks++; if (a_ready !== m_ar || b_ready !== m_br)
            $display("FAIL rand_ready_n%0d: a=%b b=%b want %b %b", n, a_ready, b_ready, m_ar, m_br); else passed++;
         @(posedge clk); @(negedge clk);
      end
      idle_inputs();
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      for (int r = 0; r < 32; r++) begin
         checks++; if (rf_dut[r] !== m_rf[r]) $display("FAIL rand_rf_x%0d: got %h want %h", r, rf_dut[r], m_rf[r]); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_b_back_to_back();
      test_contention();
      test_x0();
      test_same_addr();
      test_saturation();
      test_reset_mid_force();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
